// File: rtl/ring_pos_monitor.sv
// Registered position/direction monitor for a one-hot up/down ring counter.
// Revolution counting is built only when RING_MON_REV_CNT_EN is defined.
module ring_pos_monitor #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3,
  parameter int REV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             ring_vld,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             dir_up,
  output logic             step,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [REV_W-1:0] rev_cnt,
  output logic             rev_pulse
);

  // state | meaning
  // SYNC  | waiting for the first one-hot sample; no error raised
  // TRACK | following legal single-position moves
  // FAULT | sticky error; ring ignored until clr_err
  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_vld_q, idx_vld_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] rol_prev, ror_prev;

`ifdef RING_MON_REV_CNT_EN
  logic [REV_W-1:0] rev_q, rev_d;
  logic             rev_pulse_q, rev_pulse_d;
`endif

  function automatic logic is_onehot(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] enc(input logic [WIDTH-1:0] x);
    logic [IDX_W-1:0] e;
    e = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) e = IDX_W'(i);
    return e;
  endfunction

  assign rol_prev = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign ror_prev = {prev_q[0], prev_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    idx_d     = idx_q;
    idx_vld_d = idx_vld_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    err_d     = err_q;
    code_d    = code_q;
`ifdef RING_MON_REV_CNT_EN
    rev_d       = rev_q;
    rev_pulse_d = 1'b0;
`endif
    case (state_q)
      SYNC: begin
        if (ring_vld && is_onehot(ring_in)) begin
          prev_d    = ring_in;
          idx_d     = enc(ring_in);
          idx_vld_d = 1'b1;
          state_d   = TRACK;
        end
      end
      TRACK: begin
        if (ring_vld && (ring_in != prev_q)) begin
          if (!is_onehot(ring_in)) begin
            err_d     = 1'b1;
            code_d    = 2'b01;
            idx_vld_d = 1'b0;
            state_d   = FAULT;
          end else if (ring_in == rol_prev) begin
            step_d = 1'b1;
            dir_d  = 1'b1;
            prev_d = ring_in;
            idx_d  = enc(ring_in);
`ifdef RING_MON_REV_CNT_EN
            if (prev_q[WIDTH-1]) begin
              rev_pulse_d = 1'b1;
              rev_d       = rev_q + REV_W'(1);
            end
`endif
          end else if (ring_in == ror_prev) begin
            step_d = 1'b1;
            dir_d  = 1'b0;
            prev_d = ring_in;
            idx_d  = enc(ring_in);
`ifdef RING_MON_REV_CNT_EN
            if (prev_q[0]) begin
              rev_pulse_d = 1'b1;
              rev_d       = rev_q - REV_W'(1);
            end
`endif
          end else begin
            err_d     = 1'b1;
            code_d    = 2'b10;
            idx_vld_d = 1'b0;
            state_d   = FAULT;
          end
        end
      end
      FAULT: begin
        // Clear takes priority; a coincident sample is dropped, not evaluated.
        if (clr_err) begin
          err_d   = 1'b0;
          code_d  = 2'b00;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SYNC;
      prev_q    <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      idx_q     <= idx_d;
      idx_vld_q <= idx_vld_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

`ifdef RING_MON_REV_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rev_q       <= '0;
      rev_pulse_q <= 1'b0;
    end else begin
      rev_q       <= rev_d;
      rev_pulse_q <= rev_pulse_d;
    end
  end

  assign rev_cnt   = rev_q;
  assign rev_pulse = rev_pulse_q;
`else
  assign rev_cnt   = '0;
  assign rev_pulse = 1'b0;
`endif

  assign idx      = idx_q;
  assign idx_vld  = idx_vld_q;
  assign dir_up   = dir_q;
  assign step     = step_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule
